// File: rtl/hazard_stall_ctrl_pkg.sv
// hazard_stall_ctrl_pkg: shared Tuse/Tnew encodings, latency defaults and the per-source hazard rule.
package hazard_stall_ctrl_pkg;
  localparam logic [1:0] TUSE_BR   = 2'd0;
  localparam logic [1:0] TUSE_ALU  = 2'd1;
  localparam logic [1:0] TUSE_ST   = 2'd2;
  localparam logic [1:0] TNEW_NONE = 2'd0;
  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;
  localparam logic [4:0] REG_ZERO = 5'd0;
  // A producer only blocks the reader when its result arrives later than the reader needs it.
  function automatic logic src_hazard(input logic used, input logic [4:0] src, input logic [1:0] tuse,
                                      input logic [4:0] ex_wa, input logic [1:0] ex_tnew,
                                      input logic [4:0] mem_wa, input logic [1:0] mem_tnew);
    return used && (src != REG_ZERO) &&
           (((ex_wa == src) && (ex_tnew > tuse)) || ((mem_wa == src) && (mem_tnew > tuse)));
  endfunction
endpackage

// File: rtl/hazard_stall_ctrl_md_busy_timer.sv
// md_busy_timer: multiply/divide busy down-counter; a start while busy is ignored.
module md_busy_timer
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start,
  input  logic md_is_div,
  output logic md_busy
);
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_cnt <= '0;
    else if (md_start && r_cnt == '0) r_cnt <= md_is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
    else if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
  end
  assign md_busy = (r_cnt != '0);
endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: IF/ID hold and ID/EX bubble control from Tuse/Tnew hazards and md busy.
// Optional STALL_CNT_EN adds a free-running 32-bit stall-cycle counter.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_rs_used,
  input  logic        id_rt_used,
  input  logic [1:0]  id_tuse_rs,
  input  logic [1:0]  id_tuse_rt,
  input  logic        id_is_md,
  input  logic [4:0]  ex_wa,
  input  logic [4:0]  mem_wa,
  input  logic [1:0]  ex_tnew,
  input  logic [1:0]  mem_tnew,
  input  logic        md_start,
  input  logic        md_is_div,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_clr,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);
  logic w_rs_haz, w_rt_haz, w_md_haz, w_stall;
  md_busy_timer #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) u_timer (
    .clk(clk), .reset(reset), .md_start(md_start), .md_is_div(md_is_div), .md_busy(md_busy)
  );
  assign w_rs_haz = src_hazard(id_rs_used, id_rs, id_tuse_rs, ex_wa, ex_tnew, mem_wa, mem_tnew);
  assign w_rt_haz = src_hazard(id_rt_used, id_rt, id_tuse_rt, ex_wa, ex_tnew, mem_wa, mem_tnew);
  // md_start counts too: the timer has not loaded yet in the cycle the op sits in EX.
  assign w_md_haz = id_is_md && (md_busy || md_start);
  assign w_stall  = w_rs_haz || w_rt_haz || w_md_haz;
  assign pc_en     = ~w_stall;
  assign if_id_en  = ~w_stall;
  assign id_ex_clr = w_stall;
`ifdef STALL_CNT_EN
  logic [31:0] r_stall_cnt;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_stall_cnt <= '0;
    else if (w_stall) r_stall_cnt <= r_stall_cnt + 32'd1;
  end
  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed checks of hazard detection, md busy timing, async reset and stall count.
module tb_hazard_stall_ctrl;
  logic        clk = 1'b0, reset = 1'b0;
  logic [4:0]  id_rs, id_rt, ex_wa, mem_wa;
  logic        id_rs_used, id_rt_used, id_is_md, md_start, md_is_div;
  logic [1:0]  id_tuse_rs, id_tuse_rt, ex_tnew, mem_tnew;
  logic        pc_en, if_id_en, id_ex_clr, md_busy;
  logic [31:0] stall_cnt;
  int checks = 0, errors = 0;
`ifdef STALL_CNT_EN
  localparam logic [31:0] SC_END = 32'd8;
`else
  localparam logic [31:0] SC_END = 32'd0;
`endif

  hazard_stall_ctrl dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used),
    .id_rt_used(id_rt_used), .id_tuse_rs(id_tuse_rs), .id_tuse_rt(id_tuse_rt), .id_is_md(id_is_md),
    .ex_wa(ex_wa), .mem_wa(mem_wa), .ex_tnew(ex_tnew), .mem_tnew(mem_tnew), .md_start(md_start),
    .md_is_div(md_is_div), .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_clr(id_ex_clr),
    .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_stall(input string tag, input logic s);
    chk({tag, "_pc_en"}, {31'd0, pc_en}, {31'd0, ~s});
    chk({tag, "_if_id_en"}, {31'd0, if_id_en}, {31'd0, ~s});
    chk({tag, "_id_ex_clr"}, {31'd0, id_ex_clr}, {31'd0, s});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0; id_tuse_rs = 0; id_tuse_rt = 0;
    ex_wa = 0; mem_wa = 0; ex_tnew = 0; mem_tnew = 0;
  endtask

  task automatic load_use_rs();
    id_rs = 5'd8; id_rs_used = 1; id_tuse_rs = 2'd1; ex_wa = 5'd8; ex_tnew = 2'd2;
    #1;
    chk_stall("load_use_ex", 1'b1);
    tick();
    ex_wa = 0; ex_tnew = 0; mem_wa = 5'd8; mem_tnew = 2'd1;
    #1;
    chk_stall("load_use_mem", 1'b0);
    clr();
  endtask

  initial begin
    clr();
    id_is_md = 0; md_start = 0; md_is_div = 0;
    #12;
    chk("rst_md_busy", {31'd0, md_busy}, 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk_stall("rst", 1'b0);
    reset = 1'b1;
    tick();
    // load-use on rs, then rt
    load_use_rs();
    id_rt = 5'd12; id_rt_used = 1; id_tuse_rt = 2'd2; mem_wa = 5'd12; mem_tnew = 2'd1;
    #1;
    chk_stall("rt_store_mem_tnew1", 1'b0);
    ex_wa = 5'd12; ex_tnew = 2'd2;
    #1;
    chk_stall("rt_store_ex_tnew2", 1'b0);
    id_tuse_rt = 2'd1;
    #1;
    chk_stall("rt_alu_ex_load", 1'b1);
    tick();
    clr();
    // branch after ALU
    id_rs = 5'd9; id_rs_used = 1; id_tuse_rs = 2'd0; ex_wa = 5'd9; ex_tnew = 2'd1;
    #1;
    chk_stall("br_ex_alu", 1'b1);
    tick();
    ex_wa = 0; ex_tnew = 0; mem_wa = 5'd9; mem_tnew = 2'd0;
    #1;
    chk_stall("br_mem_done", 1'b0);
    mem_tnew = 2'd1;
    #1;
    chk_stall("br_mem_load", 1'b1);
    tick();
    clr();
    // register 0, unused source, equal Tnew/Tuse
    id_rs = 0; id_rs_used = 1; id_tuse_rs = 2'd0; ex_wa = 0; ex_tnew = 2'd2;
    #1;
    chk_stall("reg_zero", 1'b0);
    clr();
    id_rt = 5'd5; id_rt_used = 0; id_tuse_rt = 2'd0; ex_wa = 5'd5; ex_tnew = 2'd2;
    #1;
    chk_stall("rt_unused", 1'b0);
    clr();
    id_rs = 5'd7; id_rs_used = 1; id_tuse_rs = 2'd1; ex_wa = 5'd7; ex_tnew = 2'd1;
    #1;
    chk_stall("tnew_eq_tuse", 1'b0);
    mem_wa = 5'd7; mem_tnew = 2'd2;
    #1;
    chk_stall("mem_over_ex", 1'b1);
    clr();
    // div then mflo: busy for exactly 10 cycles
    md_start = 1; md_is_div = 1; id_is_md = 1;
    #1;
    chk("div_pre_busy", {31'd0, md_busy}, 32'd0);
    chk_stall("div_start_md", 1'b1);
    tick();
    md_start = 0; md_is_div = 0;
    for (int k = 0; k < 10; k++) begin
      md_start = (k == 3);
      #1;
      chk($sformatf("div_busy_%0d", k), {31'd0, md_busy}, 32'd1);
      chk($sformatf("div_stall_%0d", k), {31'd0, id_ex_clr}, 32'd1);
      tick();
    end
    md_start = 0;
    chk("div_done_busy", {31'd0, md_busy}, 32'd0);
    chk_stall("mflo_release", 1'b0);
    id_is_md = 0;
    // mult aborted by asynchronous reset
    md_start = 1; md_is_div = 0;
    tick();
    md_start = 0;
    tick();
    tick();
    chk("mult_busy_c3", {31'd0, md_busy}, 32'd1);
    id_is_md = 1;
    #1;
    chk("mult_stall_pre_rst", {31'd0, id_ex_clr}, 32'd1);
    reset = 1'b0;
    #1;
    chk("async_rst_busy", {31'd0, md_busy}, 32'd0);
    chk("async_rst_cnt", stall_cnt, 32'd0);
    chk_stall("async_rst", 1'b0);
    reset = 1'b1;
    tick();
    chk("post_rst_busy", {31'd0, md_busy}, 32'd0);
    chk_stall("post_rst", 1'b0);
    id_is_md = 0;
    // 5-cycle mult stall plus 3 load-use stalls
    md_start = 1; md_is_div = 0;
    tick();
    md_start = 0; id_is_md = 1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("mult_stall_%0d", k), {31'd0, id_ex_clr}, 32'd1);
      tick();
    end
    chk("mult_done_busy", {31'd0, md_busy}, 32'd0);
    chk_stall("mult_release", 1'b0);
    id_is_md = 0;
    for (int k = 0; k < 3; k++) load_use_rs();
    chk("stall_cnt_total", stall_cnt, SC_END);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline sequencing controller for the five-stage MIPS core. It decides each cycle whether the IF and ID stages hold and whether the ID/EX register takes a bubble. Inputs are register-dependency hazard information (Tuse/Tnew) from the decoders and the multiply/divide start pulse. It owns the multiply/divide busy timer. Its outputs drive the PC enable, the IF/ID enable and the ID/EX clear.

## Interface
- MULT_LAT, 5, busy cycles after a mult/multu start
- DIV_LAT, 10, busy cycles after a div/divu start
- CNT_W, 4, busy counter width; both latencies must lie in 1..2^CNT_W-1
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- id_rs, id_rt  in  5 each  ID-stage source register numbers
- id_rs_used, id_rt_used  in  1 each  ID instruction reads rs / rt
- id_tuse_rs, id_tuse_rt  in  2 each  Tuse (0 = branch/jr, 1 = ALU, 2 = store data)
- id_is_md  in  1  ID instruction is mult/div/mfhi/mflo/mthi/mtlo
- ex_wa, mem_wa  in  5 each  destination register in EX / MEM (0 = none)
- ex_tnew, mem_tnew  in  2 each  Tnew at that stage (EX: ALU 1, load 2; MEM: load 1, else 0)
- md_start  in  1  Start2 from ID/EX: mult/div occupies EX this cycle
- md_is_div  in  1  qualifies md_start: 1 = div/divu
- pc_en  out  1  PC register enable
- if_id_en  out  1  IF/ID register enable
- id_ex_clr  out  1  load a bubble (all-zero) into ID/EX
- md_busy  out  1  multiply/divide unit busy
- stall_cnt  out  32  stall-cycle count (only with the macro)

## Operation
- The rs hazard is asserted when all of these hold: id_rs_used; id_rs != 0; and either (ex_wa == id_rs with ex_tnew > id_tuse_rs) or (mem_wa == id_rs with mem_tnew > id_tuse_rs).
- The rt hazard uses the same rule with the rt inputs.
- The md hazard is asserted when id_is_md and (md_busy or md_start).
- stall = rs hazard OR rt hazard OR md hazard. The outputs are purely combinational from stall:
  - pc_en = ~stall
  - if_id_en = ~stall
  - id_ex_clr = stall
- Busy timer, one down-counter `cnt`:
  - When md_start is high and cnt == 0, cnt loads DIV_LAT if md_is_div, else MULT_LAT.
  - Otherwise, when cnt != 0, cnt decrements by 1.
  - md_busy = (cnt != 0).
- md_start while cnt != 0 cannot occur, because the ID stall prevents it. If it does occur, it is ignored: there is no reload and the countdown continues.
- Register 0 never creates a hazard. A match in EX takes effect regardless of a match in MEM (logical OR).

## Timing
- Reset values: cnt = 0, md_busy = 0, stall_cnt = 0. With all inputs at 0: pc_en = 1, if_id_en = 1, id_ex_clr = 0.
- Hazard outputs have zero latency (same cycle as their inputs).
- Busy timing: md_start sampled at edge t gives md_busy high from t to t+LAT, i.e. exactly LAT cycles. mfhi/mflo in ID is released on the cycle md_busy falls.
- A stall cycle freezes IF/ID and PC and inserts exactly one bubble. The stall repeats every cycle until its condition clears.
- Reset asserted mid-countdown: cnt goes to 0 asynchronously and md_busy drops without waiting for a clock edge.

## Configuration
- STALL_CNT_EN defined:
  - stall_cnt increments by 1 on every clock where stall = 1, wrapping modulo 2^32.
  - Cleared only by reset.
- STALL_CNT_EN undefined:
  - No counter register exists.
  - stall_cnt is tied to 0.

## Structure
- The shared package holds:
  - Tuse/Tnew encodings (TUSE_BR=0, TUSE_ALU=1, TUSE_ST=2; TNEW_NONE=0)
  - MULT_LAT/DIV_LAT defaults
  - register-zero constant
- One sub-module, md_busy_timer, holds the counter and md_busy. Hazard compare logic stays in hazard_stall_ctrl.

## Test plan
- Load-use: ID add with rs=8, id_tuse_rs=1; EX lw with ex_wa=8, ex_tnew=2 -> one cycle with pc_en=0, if_id_en=0, id_ex_clr=1. Next cycle mem_tnew=1 and there is no stall.
- Branch after ALU: beq with rs=9, tuse=0; EX addu with ex_wa=9, ex_tnew=1 -> stall. Then mem_tnew=0 -> no stall.
- $0 and unused source: id_rs=0 with ex_wa=0, ex_tnew=2 -> no stall. Also id_rt_used=0 with an rt match -> no stall.
- Div then mflo: md_start=1, md_is_div=1 at edge t -> md_busy high for 10 cycles. mflo held in ID (stall) through t+9, released at t+10.
- Mult with asynchronous reset at cycle 3: after md_start with md_is_div=0, drop reset mid-count -> md_busy goes to 0 immediately and no stall remains after release.
- With STALL_CNT_EN: 3 load-use stalls plus a 5-cycle mult stall -> stall_cnt = 8. Without the macro, stall_cnt stays 0.
